gcd_issue_queue: RTL and testbench
==================================

GCD_ISSUE_QUEUE -- requirements
Module: gcd_issue_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of FIFO entries (power of two, >= 2).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid_i, input, 1 bit: an upstream operand pair is offered.
REQ-006 The block SHALL have port req_ready_o, output, 1 bit: the queue can accept a pair this cycle.
REQ-007 The block SHALL have port req_a_i, input, DATA_WIDTH bits: operand A of the offered pair.
REQ-008 The block SHALL have port req_b_i, input, DATA_WIDTH bits: operand B of the offered pair.
REQ-009 The block SHALL have port core_start_o, output, 1 bit: one-cycle start pulse to the GCD core.
REQ-010 The block SHALL have port core_a_o, output, DATA_WIDTH bits: registered operand A to the core.
REQ-011 The block SHALL have port core_b_o, output, DATA_WIDTH bits: registered operand B to the core.
REQ-012 The block SHALL have port core_busy_i, input, 1 bit: the core is computing.
REQ-013 The block SHALL have port core_done_i, input, 1 bit: one-cycle pulse, the core finished its current pair.
REQ-014 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current number of queued entries.

Function
REQ-015 The block SHALL hold pairs in a circular FIFO with read and write pointers of $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty, and the pointers wrap modulo 2*DEPTH.
REQ-016 req_ready_o SHALL equal !full, combinationally from the registered count only, with no dependence on req_valid_i.
REQ-017 A push SHALL occur on any cycle where req_valid_i && req_ready_o; the entry is visible to the issue FSM on the next cycle.
REQ-018 The issue FSM SHALL have three states, IDLE, ISSUE and WAIT, with these transitions:
  - IDLE -> ISSUE when the FIFO is non-empty and !core_busy_i;
  - ISSUE -> WAIT unconditionally;
  - WAIT -> IDLE on core_done_i.
REQ-019 On the IDLE->ISSUE edge, the head entry SHALL be loaded into core_a_o/core_b_o and popped; core_a_o/core_b_o SHALL then hold that value until the next load.
REQ-020 core_start_o SHALL be high exactly during ISSUE, i.e. one cycle.
REQ-021 Minimum latency SHALL be 2 cycles: a push into an empty idle queue in cycle N gives core_start_o high in cycle N+2.
REQ-022 A simultaneous push and pop SHALL leave count_o unchanged, and both SHALL succeed.
REQ-023 When the FIFO is full, pushes SHALL be refused (ready low); a pop in that same cycle SHALL raise ready on the next cycle only.
REQ-024 core_done_i in IDLE or ISSUE SHALL be ignored.
REQ-025 core_busy_i SHALL be sampled only in IDLE.
REQ-026 Entries SHALL issue strictly in push order, and data SHALL pass unmodified except as stated in REQ-030.

Reset
REQ-027 While reset_i is high at a clock edge, the block SHALL go to IDLE, empty the FIFO (both pointers 0), and drive:
  - count_o = 0 and req_ready_o = 1;
  - core_start_o = 0;
  - core_a_o = 0 and core_b_o = 0.
REQ-028 Reset asserted mid-operation (ISSUE or WAIT, any count) SHALL discard all queued entries with no further start pulse, and a core_done_i arriving after reset SHALL be ignored.
REQ-029 FIFO storage contents need not be reset.

Configuration
REQ-030 With macro GCD_OPERAND_SORT_EN defined, the load in REQ-019 SHALL place max(a,b) on core_a_o and min(a,b) on core_b_o (unsigned compare; equal values are not swapped); without it, core_a_o = head A and core_b_o = head B with no compare logic.

Verification
REQ-031 Reset, then push (12,18) in cycle 0 with core idle -> core_start_o high in cycle 2 only, core_a_o=12 and core_b_o=18 (or 18/12 with GCD_OPERAND_SORT_EN), count_o back to 0 in cycle 3.
REQ-032 Hold core_busy_i=1 and push 4 pairs back-to-back -> count_o=4, req_ready_o=0, and a 5th valid pair is refused; release busy -> the pairs issue in order, one start per core_done_i.
REQ-033 With count_o=2, push while the FSM pops (IDLE->ISSUE) -> count_o stays 2, and the pushed entry issues third.
REQ-034 Push 10 pairs, each in the cycle after core_done_i, with DEPTH=4 -> pointers wrap, and all 10 pairs are presented in order with correct values.
REQ-035 Assert reset_i in WAIT with count_o=3, then pulse core_done_i -> no core_start_o, count_o=0, and core_a_o/core_b_o=0.
REQ-036 Under GCD_OPERAND_SORT_EN, push (7,7) and (3,250) -> core_a_o/core_b_o = 7/7, then 250/3.

Source files
------------

// File: rtl/gcd_issue_queue.sv
// Operand-pair FIFO feeding a GCD core through a three-state issue FSM.
// Optional macro GCD_OPERAND_SORT_EN: load max(a,b) into A and min(a,b) into B.
module gcd_issue_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [DATA_WIDTH-1:0]   req_a_i,
  input  logic [DATA_WIDTH-1:0]   req_b_i,
  output logic                    core_start_o,
  output logic [DATA_WIDTH-1:0]   core_a_o,
  output logic [DATA_WIDTH-1:0]   core_b_o,
  input  logic                    core_busy_i,
  input  logic                    core_done_i,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0]   r_mem_a [DEPTH];
  logic [DATA_WIDTH-1:0]   r_mem_b [DEPTH];
  logic [DATA_WIDTH-1:0]   r_core_a, r_core_b;
  logic [PW-1:0]           w_count;
  logic                    w_full, w_empty, w_push, w_pop;
  logic [DATA_WIDTH-1:0]   w_head_a, w_head_b, w_load_a, w_load_b;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_count == PW'(DEPTH));
  assign w_empty  = (w_count == '0);
  assign w_push   = req_valid_i && !w_full;
  assign w_pop    = (r_state == IDLE) && !w_empty && !core_busy_i;
  assign w_head_a = r_mem_a[r_rd_ptr[AW-1:0]];
  assign w_head_b = r_mem_b[r_rd_ptr[AW-1:0]];

`ifdef GCD_OPERAND_SORT_EN
  assign w_load_a = (w_head_a >= w_head_b) ? w_head_a : w_head_b;
  assign w_load_b = (w_head_a >= w_head_b) ? w_head_b : w_head_a;
`else
  assign w_load_a = w_head_a;
  assign w_load_b = w_head_b;
`endif

  assign req_ready_o  = !w_full;
  assign count_o      = w_count;
  assign core_start_o = (r_state == ISSUE);
  assign core_a_o     = r_core_a;
  assign core_b_o     = r_core_b;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr[AW-1:0]] <= req_a_i;
      r_mem_b[r_wr_ptr[AW-1:0]] <= req_b_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_core_a <= '0;
      r_core_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_core_a <= w_load_a;
        r_core_b <= w_load_b;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (core_done_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_gcd_issue_queue.sv
// Directed bench for gcd_issue_queue; the core side is driven by hand.
module tb_gcd_issue_queue;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_i, req_valid_i, core_busy_i, core_done_i;
  logic [DW-1:0] req_a_i, req_b_i;
  logic          req_ready_o, core_start_o;
  logic [DW-1:0] core_a_o, core_b_o;
  logic [2:0]    count_o;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .core_start_o(core_start_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_busy_i(core_busy_i), .core_done_i(core_done_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] ea(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef GCD_OPERAND_SORT_EN
    return (a >= b) ? a : b;
`else
    return a;
`endif
  endfunction

  function automatic logic [DW-1:0] eb(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef GCD_OPERAND_SORT_EN
    return (a >= b) ? b : a;
`else
    return b;
`endif
  endfunction

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid_i = 1'b1; req_a_i = a; req_b_i = b;
    tick();
    req_valid_i = 1'b0;
  endtask

  // Wait (bounded) for a start pulse, check operands, confirm it lasts one cycle, then finish the job.
  task automatic issue_one(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    while (!core_start_o && n < 12) begin tick(); n++; end
    chk({tag, "_start"}, core_start_o, 1);
    chk({tag, "_a"}, core_a_o, ea(a, b));
    chk({tag, "_b"}, core_b_o, eb(a, b));
    tick();
    chk({tag, "_pulse1"}, core_start_o, 0);
    tick();
    chk({tag, "_waitstart"}, core_start_o, 0);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  logic [DW-1:0] va [10];
  logic [DW-1:0] vb [10];

  initial begin
    reset_i = 1'b0; req_valid_i = 1'b0; req_a_i = '0; req_b_i = '0;
    core_busy_i = 1'b0; core_done_i = 1'b0;
    #1;
    do_reset();
    chk("rst_count", count_o, 0);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_start", core_start_o, 0);
    chk("rst_a", core_a_o, 0);
    chk("rst_b", core_b_o, 0);

    // Minimum latency: push in cycle 0, start in cycle 2 only.
    push(8'd12, 8'd18);
    chk("lat_c1_start", core_start_o, 0);
    chk("lat_c1_count", count_o, 1);
    tick();
    chk("lat_c2_start", core_start_o, 1);
    chk("lat_c2_a", core_a_o, ea(8'd12, 8'd18));
    chk("lat_c2_b", core_b_o, eb(8'd12, 8'd18));
    tick();
    chk("lat_c3_start", core_start_o, 0);
    chk("lat_c3_count", count_o, 0);
    core_done_i = 1'b1; tick(); core_done_i = 1'b0;

    // Fill under busy, refuse a fifth, then drain in order.
    core_busy_i = 1'b1;
    push(8'd1, 8'd2); push(8'd3, 8'd4); push(8'd5, 8'd6); push(8'd7, 8'd8);
    chk("full_count", count_o, 4);
    chk("full_ready", req_ready_o, 0);
    push(8'd99, 8'd98);
    chk("full_refused", count_o, 4);
    chk("full_nostart", core_start_o, 0);
    core_busy_i = 1'b0;
    tick();
    chk("full_pop_ready", req_ready_o, 1);
    issue_one("full0", 8'd1, 8'd2);
    issue_one("full1", 8'd3, 8'd4);
    issue_one("full2", 8'd5, 8'd6);
    issue_one("full3", 8'd7, 8'd8);
    tick(); tick();
    chk("full_drained", count_o, 0);
    chk("full_no_extra", core_start_o, 0);

    // Simultaneous push and pop with count 2.
    core_busy_i = 1'b1;
    push(8'd21, 8'd22); push(8'd23, 8'd24);
    chk("pp_count_pre", count_o, 2);
    core_busy_i = 1'b0;
    push(8'd25, 8'd26);
    chk("pp_count", count_o, 2);
    issue_one("pp0", 8'd21, 8'd22);
    issue_one("pp1", 8'd23, 8'd24);
    issue_one("pp2", 8'd25, 8'd26);

    // Ten pairs, each pushed in the cycle after done: pointers wrap.
    for (int i = 0; i < 10; i++) begin
      va[i] = DW'(8'd40 + 8'(i * 3));
      vb[i] = DW'(8'd200 - 8'(i * 7));
    end
    for (int i = 0; i < 10; i++) begin
      push(va[i], vb[i]);
      issue_one($sformatf("wrap%0d", i), va[i], vb[i]);
    end
    chk("wrap_count", count_o, 0);

    // Reset while in WAIT with three entries queued.
    core_busy_i = 1'b1;
    push(8'd11, 8'd12); push(8'd13, 8'd14); push(8'd15, 8'd16); push(8'd17, 8'd18);
    core_busy_i = 1'b0;
    tick();
    chk("rw_issue", core_start_o, 1);
    tick();
    chk("rw_count3", count_o, 3);
    do_reset();
    core_done_i = 1'b1; tick(); core_done_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rw_nostart", core_start_o, 0);
      tick();
    end
    chk("rw_count", count_o, 0);
    chk("rw_ready", req_ready_o, 1);
    chk("rw_a", core_a_o, 0);
    chk("rw_b", core_b_o, 0);

    // Operand ordering: equal pair and a small-first pair.
    push(8'd7, 8'd7);
    issue_one("ord0", 8'd7, 8'd7);
    push(8'd3, 8'd250);
    issue_one("ord1", 8'd3, 8'd250);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
